// File: rtl/cache_arbiter.sv
// Cache arbiter: shares one cacheline-adaptor port between the I-cache and D-cache.
// One transaction at a time; address/wdata are latched at grant and held until mem_resp.
module cache_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

    state_e state;
    logic   last_grant_d;  // 1: last transaction went to the D-cache
    logic   i_req;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    // Grant decision while idle; ties broken by round robin or fixed D priority
    always_comb begin
        i_req   = i_pmem_read;
        d_req   = d_pmem_read | d_pmem_write;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if (ROUND_ROBIN != 0) begin
                grant_d = ~last_grant_d;
            end else begin
                grant_d = 1'b1;
            end
            grant_i = ~grant_d;
        end else begin
            grant_d = d_req;
            grant_i = i_req;
        end
    end

    // Arbitration FSM with registered request/address/data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            last_grant_d <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (grant_d) begin
                        state        <= StServeD;
                        last_grant_d <= 1'b1;
                        mem_address  <= d_pmem_address;
                        mem_wdata    <= d_pmem_wdata;
                        // Read and write together is treated as a writeback
                        mem_write    <= d_pmem_write;
                        mem_read     <= ~d_pmem_write;
                    end else if (grant_i) begin
                        state        <= StServeI;
                        last_grant_d <= 1'b0;
                        mem_address  <= i_pmem_address;
                        mem_read     <= 1'b1;
                        mem_write    <= 1'b0;
                    end
                end
                StServeI, StServeD: begin
                    if (mem_resp) begin
                        state     <= StIdle;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Route the adaptor response to the granted cache only; suppressed during reset
    always_comb begin
        i_pmem_resp  = (state == StServeI) && mem_resp && !rst;
        d_pmem_resp  = (state == StServeD) && mem_resp && !rst;
        i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
        d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;
    end

endmodule
